// File: rtl/vga_pixel_feeder.sv
// Pixel FIFO that aligns an upstream RGB stream to the display timing using sof markers.
// Optional error statistics output err_cnt when VGA_PIXEL_FEEDER_STATS_EN is defined.
module vga_pixel_feeder #(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int DEPTH = 64
) (
   input  logic        pixel_clk,
   input  logic        pixel_rst,
   input  logic [23:0] s_data,
   input  logic        s_sof,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        frame_start,
   input  logic        pix_req,
   output logic [23:0] pix_rgb,
   output logic        sync_err,
   input  logic        clr_err
`ifdef VGA_PIXEL_FEEDER_STATS_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int TOTAL = HDISP * VDISP;
   localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [CW-1:0] LAST_PIX = CW'(TOTAL - 1);

   typedef enum logic [1:0] {SYNC, ARMED, STREAM} state_t;

   logic [24:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   fill_reg;
   logic [AW:0]   fill_next;
   logic          full_reg;
   logic          empty;
   logic          push;
   logic          pop;
   logic [24:0]   head;
   logic          head_sof;
   logic          head_ok;

   state_t        state_reg;
   state_t        state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          out_load;
   logic          err_set;
   logic [23:0]   pix_rgb_reg;
   logic          sync_err_reg;

   assign s_ready  = !full_reg && !pixel_rst;
   assign push     = s_valid && s_ready;
   assign empty    = (fill_reg == '0);
   // Asynchronous read of the head: the FSM must inspect sof before deciding to pop.
   assign head     = mem[rd_ptr_reg];
   assign head_sof = head[24];
   assign head_ok  = head_sof ? (cnt_reg == '0) : (cnt_reg != '0);
   assign fill_next = fill_reg + (AW+1)'(push) - (AW+1)'(pop);

   always_ff @(posedge pixel_clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {s_sof, s_data};
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
         full_reg   <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         fill_reg <= fill_next;
         full_reg <= (fill_next == (AW+1)'(DEPTH));
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pop        = 1'b0;
      out_load   = 1'b0;
      err_set    = 1'b0;
      case (state_reg)
         SYNC: begin
            if (!empty) begin
               if (head_sof) state_next = ARMED;
               else          pop        = 1'b1;
            end
         end
         ARMED: begin
            if (frame_start) begin
               state_next = STREAM;
               cnt_next   = '0;
            end
         end
         STREAM: begin
            if (frame_start && cnt_reg != '0) begin
               err_set    = 1'b1;
               state_next = SYNC;
               cnt_next   = '0;
            end else if (pix_req) begin
               if (empty || !head_ok) begin
                  err_set    = 1'b1;
                  state_next = SYNC;
                  cnt_next   = '0;
               end else begin
                  pop      = 1'b1;
                  out_load = 1'b1;
                  if (cnt_reg == LAST_PIX) begin
                     state_next = SYNC;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end
         end
         default: state_next = SYNC;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         state_reg    <= SYNC;
         cnt_reg      <= '0;
         pix_rgb_reg  <= '0;
         sync_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pix_rgb_reg <= out_load ? head[23:0] : 24'h0;
         if (err_set)      sync_err_reg <= 1'b1;
         else if (clr_err) sync_err_reg <= 1'b0;
      end
   end

   assign pix_rgb  = pix_rgb_reg;
   assign sync_err = sync_err_reg;

`ifdef VGA_PIXEL_FEEDER_STATS_EN
   logic [15:0] err_cnt_reg;

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         err_cnt_reg <= '0;
      end else if (err_set && err_cnt_reg != 16'hFFFF) begin
         err_cnt_reg <= err_cnt_reg + 16'd1;
      end
   end

   assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder (HDISP=4, VDISP=2, DEPTH=4) with an output scoreboard.
module tb_vga_pixel_feeder;

   logic        pixel_clk = 1'b0;
   logic        pixel_rst = 1'b1;
   logic [23:0] s_data    = '0;
   logic        s_sof     = 1'b0;
   logic        s_valid   = 1'b0;
   logic        s_ready;
   logic        frame_start = 1'b0;
   logic        pix_req   = 1'b0;
   logic [23:0] pix_rgb;
   logic        sync_err;
   logic        clr_err   = 1'b0;
`ifdef VGA_PIXEL_FEEDER_STATS_EN
   logic [15:0] err_cnt;
`endif

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;
   int push_cnt  = 0;
   logic [24:0] src_q [$];
   logic [23:0] exp_q [$];

   always #5 pixel_clk = ~pixel_clk;

   vga_pixel_feeder #(.HDISP(4), .VDISP(2), .DEPTH(4)) dut (
      .pixel_clk  (pixel_clk),
      .pixel_rst  (pixel_rst),
      .s_data     (s_data),
      .s_sof      (s_sof),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .frame_start(frame_start),
      .pix_req    (pix_req),
      .pix_rgb    (pix_rgb),
      .sync_err   (sync_err),
      .clr_err    (clr_err)
`ifdef VGA_PIXEL_FEEDER_STATS_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive source head and controls, then score pix_rgb for a request.
   task automatic tick(input logic fs, input logic pr, input logic clr, input logic [23:0] e);
      logic acc;
      logic [23:0] want;
      s_valid = (src_q.size() != 0);
      if (s_valid) {s_sof, s_data} = src_q[0];
      else         {s_sof, s_data} = '0;
      frame_start = fs;
      pix_req     = pr;
      clr_err     = clr;
      if (pr) exp_q.push_back(e);
      #1;
      acc = s_valid && s_ready;
      @(posedge pixel_clk);
      #1;
      if (acc) begin
         src_q.delete(0);
         push_cnt++;
      end
      if (pr) begin
         want = exp_q.pop_front();
         chk("pix_rgb", 32'(pix_rgb), 32'(want));
      end
      frame_start = 1'b0;
      pix_req     = 1'b0;
      clr_err     = 1'b0;
   endtask

   task automatic load(input logic [23:0] base, input int n);
      for (int i = 0; i < n; i++) src_q.push_back({(i == 0), base + 24'(i)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 24'h0);
   endtask

   task automatic stream(input logic [23:0] base, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, base + 24'(i));
   endtask

   initial begin
      // Reset state
      @(posedge pixel_clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
      chk("rst_sync_err", 32'(sync_err), 32'd0);
      pixel_rst = 1'b0;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);

      // Full frame with backpressure: FIFO fills to 4, then streams 1..8
      load(24'd1, 8);
      push_cnt = 0;
      idle(6);
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("pushes_at_full", 32'(push_cnt), 32'd4);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      stream(24'd1, 8);
      chk("frame_sync_err", 32'(sync_err), 32'd0);
      tick(1'b0, 1'b1, 1'b0, 24'h0);
      chk("idle_req_sync_err", 32'(sync_err), 32'd0);

      // Junk words ahead of a frame are dropped in SYNC
      src_q.push_back({1'b0, 24'hAAAAAA});
      src_q.push_back({1'b0, 24'hBBBBBB});
      load(24'h10, 8);
      idle(6);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      stream(24'h10, 8);
      chk("junk_sync_err", 32'(sync_err), 32'd0);

      // Underflow on the 4th request
      load(24'h21, 3);
      idle(4);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      stream(24'h21, 3);
      tick(1'b0, 1'b1, 1'b0, 24'h0);
      chk("underflow_sync_err", 32'(sync_err), 32'd1);
      tick(1'b0, 1'b1, 1'b0, 24'h0);
      chk("underflow_sticky", 32'(sync_err), 32'd1);
      tick(1'b0, 1'b0, 1'b1, 24'h0);
      chk("clr_err", 32'(sync_err), 32'd0);
`ifdef VGA_PIXEL_FEEDER_STATS_EN
      chk("err_cnt_1", 32'(err_cnt), 32'd1);
`endif

      // Early sof at pixel 3: error, word kept as head, re-armed; set beats clear
      src_q.push_back({1'b1, 24'h41});
      src_q.push_back({1'b0, 24'h42});
      load(24'h43, 8);
      idle(5);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      tick(1'b0, 1'b1, 1'b0, 24'h41);
      tick(1'b0, 1'b1, 1'b0, 24'h42);
      tick(1'b0, 1'b1, 1'b1, 24'h0);
      chk("early_sof_err_over_clr", 32'(sync_err), 32'd1);
      idle(1);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      stream(24'h43, 8);
      chk("resync_err_sticky", 32'(sync_err), 32'd1);
      tick(1'b0, 1'b0, 1'b1, 24'h0);
      chk("clr_err_2", 32'(sync_err), 32'd0);
`ifdef VGA_PIXEL_FEEDER_STATS_EN
      chk("err_cnt_2", 32'(err_cnt), 32'd2);
`endif

      // Reset in STREAM with a valid request pending
      load(24'h51, 8);
      idle(5);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      src_q.delete();
      s_valid   = 1'b0;
      pixel_rst = 1'b1;
      pix_req   = 1'b1;
      #1;
      chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
      @(posedge pixel_clk);
      #1;
      pixel_rst = 1'b0;
      pix_req   = 1'b0;
      #1;
      chk("mid_rst_pix_rgb", 32'(pix_rgb), 32'd0);
      chk("mid_rst_s_ready_after", 32'(s_ready), 32'd1);
`ifdef VGA_PIXEL_FEEDER_STATS_EN
      chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      // Stale sof word 0x51 must be gone: the next frame starts at 0x61
      load(24'h61, 8);
      idle(5);
      tick(1'b1, 1'b0, 1'b0, 24'h0);
      stream(24'h61, 8);
      chk("post_rst_sync_err", 32'(sync_err), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
